// File: rtl/lc_dco_fll_pkg.sv
// Shared types and code-range constants for the LC-DCO frequency-locked-loop controller.
package lc_dco_fll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_DECIDE
   } fll_state_e;

   typedef enum logic {
      MODE_SAR,
      MODE_TRACK
   } fll_mode_e;

   localparam logic [7:0] SW_MIN = 8'd1;
   localparam logic [7:0] SW_MAX = 8'd255;

endpackage

// File: rtl/lc_dco_edge_sync.sv
// Brings the asynchronous divided DCO clock into the reference domain and
// emits a one-cycle pulse per rising edge.
module lc_dco_edge_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_rise
);

   // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
   logic [2:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_sync <= '0;
      else         r_sync <= {r_sync[1:0], i_async};
   end

   assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/lc_dco_fll_ctrl.sv
// FLL controller: counts div_clk edges per reference window, runs an 8-step SAR
// search on the DCO cap-bank code, then optionally tracks with +/-1 LSB steps.
module lc_dco_fll_ctrl
   import lc_dco_fll_pkg::*;
#(
   parameter int         CNT_W      = 16,
   parameter int         WIN_CYC    = 1000,
   parameter int         SETTLE_CYC = 16,
   parameter int         TOL        = 2,
   parameter logic [7:0] SW_RESET   = 8'h80
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_track_en,
   input  logic [CNT_W-1:0] i_target_cnt,
   input  logic             i_div_clk,
   output logic [7:0]       o_sw,
   output logic             o_busy,
   output logic             o_locked,
   output logic             o_oor,
   output logic [CNT_W-1:0] o_meas_cnt,
   output logic             o_meas_valid
);

   localparam int CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
   localparam int CYC_W   = $clog2(CYC_MAX + 1);
   localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0] WIN_LAST    = CYC_W'(WIN_CYC - 1);
   localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(TOL);

   fll_state_e       r_state, w_state_nxt;
   fll_mode_e        r_mode, w_mode_nxt;
   logic [7:0]       r_sw, w_sw_nxt, w_sar_sw;
   logic [2:0]       r_bit, w_bit_nxt;
   logic             r_locked, w_locked_nxt;
   logic             r_oor, w_oor_nxt;
   logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [CNT_W-1:0] r_meas_cnt, w_meas_nxt;
   logic             r_meas_valid, w_mvalid_nxt;
   logic             w_rise;
   logic [CNT_W:0]   w_cnt_ext, w_tgt_ext;
   logic             w_too_fast, w_too_slow;

   lc_dco_edge_sync u_edge_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_div_clk),
      .o_rise  (w_rise)
   );

   // Dead-band compare at CNT_W+1 bits so target+/-TOL never wraps.
   assign w_cnt_ext  = {1'b0, r_cnt};
   assign w_tgt_ext  = {1'b0, i_target_cnt};
   assign w_too_fast = w_cnt_ext > (w_tgt_ext + TOL_EXT);
   assign w_too_slow = (w_cnt_ext + TOL_EXT) < w_tgt_ext;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_SAR;
         r_sw         <= SW_RESET;
         r_bit        <= 3'd7;
         r_locked     <= 1'b0;
         r_oor        <= 1'b0;
         r_cyc        <= '0;
         r_cnt        <= '0;
         r_meas_cnt   <= '0;
         r_meas_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_mode       <= w_mode_nxt;
         r_sw         <= w_sw_nxt;
         r_bit        <= w_bit_nxt;
         r_locked     <= w_locked_nxt;
         r_oor        <= w_oor_nxt;
         r_cyc        <= w_cyc_nxt;
         r_cnt        <= w_cnt_nxt;
         r_meas_cnt   <= w_meas_nxt;
         r_meas_valid <= w_mvalid_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_sw_nxt     = r_sw;
      w_bit_nxt    = r_bit;
      w_locked_nxt = r_locked;
      w_oor_nxt    = r_oor;
      w_cyc_nxt    = r_cyc + 1'b1;
      w_cnt_nxt    = r_cnt;
      w_meas_nxt   = r_meas_cnt;
      w_mvalid_nxt = 1'b0;

      // Equality clears the bit: only a strictly-too-fast DCO keeps it set.
      w_sar_sw = r_sw;
      if (!(r_cnt > i_target_cnt)) w_sar_sw[r_bit] = 1'b0;
      if (r_bit != 3'd0)           w_sar_sw[r_bit - 3'd1] = 1'b1;
      else if (w_sar_sw == 8'd0)   w_sar_sw = SW_MIN;

      unique case (r_state)
         ST_IDLE: begin
            w_cyc_nxt = '0;
            if (i_start) begin
               w_state_nxt  = ST_SETTLE;
               w_sw_nxt     = SW_RESET;
               w_bit_nxt    = 3'd7;
               w_mode_nxt   = MODE_SAR;
               w_locked_nxt = 1'b0;
               w_oor_nxt    = 1'b0;
            end
         end
         ST_SETTLE: begin
            if (r_cyc == SETTLE_LAST) begin
               w_state_nxt = ST_MEASURE;
               w_cyc_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         end
         ST_MEASURE: begin
            if (w_rise && (r_cnt != '1)) w_cnt_nxt = r_cnt + 1'b1;
            if (r_cyc == WIN_LAST) w_state_nxt = ST_DECIDE;
         end
         ST_DECIDE: begin
            w_meas_nxt   = r_cnt;
            w_mvalid_nxt = 1'b1;
            w_cyc_nxt    = '0;
            w_state_nxt  = ST_SETTLE;
            if (r_mode == MODE_SAR) begin
               w_sw_nxt = w_sar_sw;
               if (r_bit != 3'd0) begin
                  w_bit_nxt = r_bit - 3'd1;
               end else begin
                  w_locked_nxt = 1'b1;
                  if (i_track_en) w_mode_nxt  = MODE_TRACK;
                  else            w_state_nxt = ST_IDLE;
               end
            end else begin
               if (w_too_fast) begin
                  if (r_sw == SW_MAX) begin
                     w_oor_nxt    = 1'b1;
                     w_locked_nxt = 1'b0;
                  end else begin
                     w_sw_nxt = r_sw + 8'd1;
                  end
               end else if (w_too_slow) begin
                  if (r_sw == SW_MIN) begin
                     w_oor_nxt    = 1'b1;
                     w_locked_nxt = 1'b0;
                  end else begin
                     w_sw_nxt = r_sw - 8'd1;
                  end
               end
               if (!i_track_en) w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_sw         = r_sw;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_locked     = r_locked;
   assign o_oor        = r_oor;
   assign o_meas_cnt   = r_meas_cnt;
   assign o_meas_valid = r_meas_valid;

endmodule

// File: tb/tb_lc_dco_fll_ctrl.sv
// Directed bench for the FLL controller with a behavioural DCO whose div_clk
// period is 20 ns + 0.25 ns * sw (delays expressed in ps-sized integer units).
module tb_lc_dco_fll_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic        track_en = 1'b0;
   logic [15:0] target = 16'd250;
   logic [3:0]  target2 = 4'd3;
   logic        div_clk = 1'b0;
   logic        tie_low = 1'b0;
   int          off_half = 10000;

   logic [7:0]  sw, sw2;
   logic        busy, locked, oor, meas_valid;
   logic        busy2, locked2, oor2, meas_valid2;
   logic [15:0] meas_cnt;
   logic [3:0]  meas_cnt2;

   int n_chk = 0;
   int n_err = 0;
   int mv_cnt = 0;

   lc_dco_fll_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_track_en(track_en),
      .i_target_cnt(target), .i_div_clk(div_clk), .o_sw(sw), .o_busy(busy),
      .o_locked(locked), .o_oor(oor), .o_meas_cnt(meas_cnt), .o_meas_valid(meas_valid)
   );

   lc_dco_fll_ctrl #(.CNT_W(4), .WIN_CYC(200), .SETTLE_CYC(4)) dut_sat (
      .i_clk(clk), .i_reset(reset), .i_start(start2), .i_track_en(1'b0),
      .i_target_cnt(target2), .i_div_clk(div_clk), .o_sw(sw2), .o_busy(busy2),
      .o_locked(locked2), .o_oor(oor2), .o_meas_cnt(meas_cnt2), .o_meas_valid(meas_valid2)
   );

   always #5000 clk = ~clk;

   // Odd start phase keeps div_clk toggles off the clk edges for every code.
   initial begin
      #1234;
      forever begin
         if (tie_low) begin
            div_clk = 1'b0;
            #125;
         end else begin
            #(off_half + 125 * int'(sw)) div_clk = ~div_clk;
         end
      end
   end

   always @(negedge clk) if (meas_valid) mv_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_mv();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1500 && !seen; i++) begin
         @(negedge clk);
         if (meas_valid) seen = 1'b1;
      end
      if (!seen) chk("mv_timeout", 0, 1);
   endtask

   task automatic pulse_start();
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic do_reset();
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   initial begin
      int n, mv0, c;
      logic [7:0] prev, exp_sw;
      bit seen2;

      // 1: reset values, then reset aborting a measurement
      tick(2);
      chk("rst_sw", sw, 8'h80);
      chk("rst_busy", busy, 0);
      chk("rst_locked", locked, 0);
      chk("rst_oor", oor, 0);
      chk("rst_mvalid", meas_valid, 0);
      chk("rst_mcnt", meas_cnt, 0);
      reset = 1'b0;
      pulse_start();
      tick(66);
      chk("mid_busy", busy, 1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("abort_sw", sw, 8'h80);
      chk("abort_busy", busy, 0);
      chk("abort_locked", locked, 0);
      chk("abort_mcnt", meas_cnt, 0);
      tick(3);
      chk("abort_idle", busy, 0);

      // 2: SAR to 250 edges, with a start pulse while busy that must be ignored
      target = 16'd250;
      track_en = 1'b0;
      off_half = 10000;
      tick(1);
      mv0 = mv_cnt;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n = 1;
      while (n < 9000) begin
         @(posedge clk);
         n++;
         #1;
         start = (n == 3000);
         if (!busy) break;
      end
      start = 1'b0;
      tick(1);
      chk("sar_latency", n, 8137);
      chk("sar_mv_pulses", mv_cnt - mv0, 8);
      chk("sar_sw_range", (sw >= 8'd79 && sw <= 8'd81), 1);
      chk("sar_locked", locked, 1);
      chk("sar_oor", oor, 0);

      // 4/5: lock then track a slower DCO; drop track_en afterwards
      track_en = 1'b1;
      pulse_start();
      repeat (8) wait_mv();
      chk("trk_lock", locked, 1);
      chk("trk_lock_sw", sw, 79);
      prev = sw;
      wait_mv();
      chk("trk_hold", sw, prev);
      off_half = 11000;
      for (int k = 0; k < 12; k++) begin
         wait_mv();
         c = int'(meas_cnt);
         if (c > 252)      exp_sw = prev + 8'd1;
         else if (c < 248) exp_sw = prev - 8'd1;
         else              exp_sw = prev;
         chk("trk_step", sw, exp_sw);
         prev = exp_sw;
         if (c >= 248 && c <= 252) break;
      end
      chk("trk_final_sw", sw, 73);
      chk("trk_oor", oor, 0);
      chk("trk_locked", locked, 1);
      track_en = 1'b0;
      wait_mv();
      chk("trk_exit_busy", busy, 0);
      chk("trk_exit_sw", sw, 73);

      // 3: dead oscillator drives every bit to 0, forced to 1, then bottom rail
      do_reset();
      tie_low = 1'b1;
      track_en = 1'b1;
      target = 16'd250;
      pulse_start();
      repeat (8) wait_mv();
      chk("dead_sw", sw, 1);
      chk("dead_locked", locked, 1);
      chk("dead_mcnt", meas_cnt, 0);
      wait_mv();
      chk("dead_oor", oor, 1);
      chk("dead_unlocked", locked, 0);
      chk("dead_sw_rail", sw, 1);
      chk("dead_busy", busy, 1);
      do_reset();
      chk("dead_rst_oor", oor, 0);
      tie_low = 1'b0;
      track_en = 1'b0;

      // 6a: count equals target exactly at bit 7 -> bit cleared
      off_half = 9000;
      target = 16'd200;
      tick(20);
      pulse_start();
      wait_mv();
      chk("eq_cnt", meas_cnt, 200);
      chk("eq_bit7_clr", sw, 8'h40);
      do_reset();

      // 6b: 4-bit counter saturates
      tick(1);
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      seen2 = 1'b0;
      for (int i = 0; i < 400 && !seen2; i++) begin
         @(negedge clk);
         if (meas_valid2) seen2 = 1'b1;
      end
      chk("sat_seen", seen2, 1);
      chk("sat_cnt", meas_cnt2, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
